// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single off-chip memory port between the I-cache
// fill path and the D-cache fill/write-back path, one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int D_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0] state;
    logic       last_d;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    assign d_req = d_read | d_write;
    // On a tie D wins under fixed priority, otherwise whoever was not served last.
    assign grant_d = (state == IDLE) && d_req && (!i_read || (D_PRIO != 0) || !last_d);
    assign grant_i = (state == IDLE) && i_read && !grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_i || grant_d) begin
            state     <= grant_d ? BUSY_D : BUSY_I;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_read  <= grant_i || !d_write;
            mem_write <= grant_d && d_write;
            if (grant_d && d_write)
                mem_wdata <= d_wdata;
        end else if (state != IDLE && mem_ready) begin
            state     <= IDLE;
            last_d    <= (state == BUSY_D);
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    assign i_ready = mem_ready && (state == BUSY_I);
    assign d_ready = mem_ready && (state == BUSY_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss path and the D-cache miss/write-back path of the RISC-V core.
- Sits between both caches and the slow memory model.
- Accepts one transaction at a time, latches its address/data, drives the memory port until mem_ready, then routes the response back to the owning cache.
- Selects the next owner by fixed D priority or by round-robin.

Parameters:
- ADDR_W, 28, block-address width (word address >> 2).
- DATA_W, 128, cache-line width.
- D_PRIO, 1, 1 = D-side always wins ties; 0 = round-robin on ties.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_read  input  1  I-cache line-fill request; held until i_ready.
- i_addr  input  ADDR_W  I-cache request address.
- i_rdata  output  DATA_W  read data to I-cache.
- i_ready  output  1  one-cycle completion pulse to I-cache.
- d_read  input  1  D-cache line-fill request; held until d_ready.
- d_write  input  1  D-cache write-back request; held until d_ready.
- d_addr  input  ADDR_W  D-cache request address.
- d_wdata  input  DATA_W  D-cache write-back data.
- d_rdata  output  DATA_W  read data to D-cache.
- d_ready  output  1  one-cycle completion pulse to D-cache.
- mem_read  output  1  memory read strobe, held for the whole transaction.
- mem_write  output  1  memory write strobe, held for the whole transaction.
- mem_addr  output  ADDR_W  latched transaction address.
- mem_wdata  output  DATA_W  latched write data.
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready.
- mem_ready  input  1  memory completion, one cycle.

Behaviour:

Clock and reset:
- One clock, clk.
- rst is asynchronous and active-high.
- On rst: state=IDLE, last_owner=I, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_ready=0, d_ready=0.

States:
- IDLE, BUSY_I, BUSY_D.

IDLE:
- d_req = d_read|d_write.
- If only i_read is high, go to BUSY_I.
- If only d_req is high, go to BUSY_D.
- If both are high:
  - D_PRIO=1: go to BUSY_D.
  - D_PRIO=0: go to BUSY_D if last_owner==I, else BUSY_I.
- On the grant edge, register the owner's address into mem_addr. For a D write, register d_wdata into mem_wdata.
- Set mem_read (I grant, or D grant with d_write=0) or mem_write (D grant with d_write=1) on the same edge. The strobe is first visible 1 cycle after the request.
- If d_read and d_write are both high, treat the request as a write.

BUSY_x:
- Hold mem_read/mem_write, mem_addr and mem_wdata constant, regardless of any request-input changes.
- When mem_ready=1:
  - Assert x_ready combinationally in that same cycle: i_ready = mem_ready & (state==BUSY_I), and likewise for D.
  - On the next edge: go to IDLE, clear the strobes, set last_owner=x.
- A new grant is possible no earlier than 1 cycle after IDLE is entered. Minimum gap between transactions is 1 idle cycle.

Response data:
- i_rdata = d_rdata = mem_rdata, unconditionally. Each cache qualifies it with its own ready.
- ready never pulses for the non-owner.

Request rules:
- A request line seen high in IDLE is a new transaction.
- Caches drop their request in the cycle after ready.

Other boundary conditions:
- mem_ready while in IDLE is ignored; no ready pulse is produced.
- Reset asserted mid-transaction aborts it immediately, with no ready pulse. The requester must re-issue.
- A request that arrives while BUSY is held off (not latched) until IDLE.
- No timeout: the block waits indefinitely for mem_ready.

Test Plan:
- Single I read: i_read=1, i_addr=28'h0000010. Next cycle mem_read=1, mem_addr=0x10. Memory returns mem_ready after 8 cycles with mem_rdata=128'hDEAD…BEEF. i_ready pulses 1 cycle carrying that data, d_ready stays 0, and mem_read drops the following cycle.
- D write-back: d_write=1, d_addr=0x20, d_wdata=128'h1234…. mem_write=1 with the latched data, held even if d_wdata changes mid-wait. d_ready pulses on mem_ready; mem_read stays 0 throughout.
- Simultaneous requests, D_PRIO=1: i_read and d_read rise together at 0x30/0x40. D is served first (mem_addr=0x40), then after 1 idle cycle I is served (mem_addr=0x30).
- Round-robin, D_PRIO=0: both request continuously for 4 transactions. Grant order is D, I, D, I (last_owner reset to I).
- Spurious mem_ready in IDLE, and d_read and d_write both high: the stray ready yields no ready pulse and no state change; the dual request issues mem_write only.
- Reset mid-transaction: assert rst while in BUSY_I. All strobes go to 0 immediately and no i_ready pulse is produced. After release, a held i_read is re-granted 1 cycle later.
